pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 43 ++++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: status codes, icodes, register ids and run-state encodings.
package pipe_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [1:0] RS_RUN   = 2'd0;
    localparam logic [1:0] RS_HALT  = 2'd1;
    localparam logic [1:0] RS_FAULT = 2'd2;

    function automatic logic stat_exc(input logic [3:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection; produces the pipeline controls used while running.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       f_stall,
    output logic       d_stall,
    output logic       d_bubble,
    output logic       e_bubble,
    output logic       m_bubble,
    output logic       w_stall
);

    logic load_use;
    logic ret_pend;
    logic mispred;
    logic exc;

    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != REG_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;
        exc      = stat_exc(m_stat) || stat_exc(W_stat);

        f_stall  = load_use | ret_pend;
        d_stall  = load_use;
        // A load/use stall keeps the RET-era instruction in decode rather than squashing it.
        d_bubble = mispred | (ret_pend & ~load_use);
        e_bubble = mispred | load_use;
        m_bubble = exc;
        w_stall  = (W_stat != STAT_AOK);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: fetch PC register, run/halt/fault state machine and performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      f_predPC,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic [63:0]      F_predPC,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [1:0]       run_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [63:0]      pc_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;
    logic             run_mode;
    logic             retire;
    logic             hd_f_stall;
    logic             hd_d_stall;
    logic             hd_d_bubble;
    logic             hd_e_bubble;
    logic             hd_m_bubble;
    logic             hd_w_stall;

    hazard_detect u_hazard (
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .f_stall  (hd_f_stall),
        .d_stall  (hd_d_stall),
        .d_bubble (hd_d_bubble),
        .e_bubble (hd_e_bubble),
        .m_bubble (hd_m_bubble),
        .w_stall  (hd_w_stall)
    );

    // A reset cycle behaves like RUN even if the state register still holds HALT/FAULT.
    always_comb begin
        run_mode = (state_q == RS_RUN) || !rst_n;
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        if (run_mode) begin
            F_stall  = hd_f_stall;
            D_stall  = hd_d_stall;
            D_bubble = hd_d_bubble;
            E_bubble = hd_e_bubble;
            M_bubble = hd_m_bubble;
            W_stall  = hd_w_stall;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RS_RUN) begin
            if (W_stat == STAT_HLT) begin
                state_d = RS_HALT;
            end else if ((W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
                state_d = RS_FAULT;
            end
        end
    end

    assign retire = (state_q == RS_RUN) && (W_stat == STAT_AOK) && (W_icode != I_NOP) &&
                    !W_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RS_RUN;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == RS_RUN) && !F_stall) begin
                pc_q <= f_predPC;
            end
            // The edge that leaves RUN is not counted, so counters freeze at their pre-stop value.
            if ((state_q == RS_RUN) && (state_d == RS_RUN) && (cyc_q != CNT_MAX)) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (retire && (ret_q != CNT_MAX)) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign F_predPC    = pc_q;
    assign run_state   = state_q;
    assign cycle_cnt   = cyc_q;
    assign retired_cnt = ret_q;

endmodule
